intersection: RTL and testbench

- Pipelined fixed-point ray/triangle intersection test (Möller–Trumbore), used by the ray-tracing core.
- Takes one triangle (A, B, C) and one ray (origin E, direction D) per cycle.
- Outputs the unnormalised face normal (B−A)×(C−A), a hit flag, and an invalid flag for degenerate/overflow cases.
- No divider: all parametric tests are done by sign-aware cross-multiplied comparisons.

---
 rtl/ray_pkg.sv | 29 ++
 rtl/cross3.sv | 19 +
 rtl/intersection.sv | 151 +++++++++++++++
 tb/tb_intersection.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ray_pkg.sv
// Shared types and fixed-point constants for the ray/triangle intersection pipeline.
// All geometry is signed Q16.16; intermediate widths grow so no stage can wrap.
package ray_pkg;

  localparam int FRAC_BITS = 16;
  localparam logic [31:0] ONE = 32'h0001_0000;

  localparam int EW = 33;             // edge / offset vectors, Q16.16
  localparam int CW = 2*EW + 1;       // cross products, Q32.32
  localparam int DW = 101;            // triple products, Q48.48
  localparam int NW = CW - FRAC_BITS; // normal after dropping fraction bits

  typedef logic signed [0:2][31:0] vec3_t;
  typedef vec3_t [0:1] ray_t;
  typedef vec3_t [0:2] triangle_t;

  typedef logic [0:2][EW-1:0] evec_t;
  typedef logic [0:2][CW-1:0] cvec_t;

  function automatic logic signed [EW-1:0] sx(input logic [31:0] x);
    return {x[31], x};
  endfunction

  // True when a shifted normal component still fits a 32-bit signed word.
  function automatic logic fits32(input logic [NW-1:0] x);
    return (&x[NW-1:31]) | ~(|x[NW-1:31]);
  endfunction

endpackage

// File: rtl/cross3.sv
// Combinational signed 3-vector cross product; the result is exact at 2*W+1 bits.
module cross3 #(
  parameter int W = 33
) (
  input  logic [0:2][W-1:0] a_i,
  input  logic [0:2][W-1:0] b_i,
  output logic [0:2][2*W:0] c_o
);

  localparam int OW = 2*W + 1;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      c_o[i] = OW'($signed(a_i[(i+1)%3])) * OW'($signed(b_i[(i+2)%3]))
             - OW'($signed(a_i[(i+2)%3])) * OW'($signed(b_i[(i+1)%3]));
    end
  end

endmodule

// File: rtl/intersection.sv
// Four-stage Moller-Trumbore ray/triangle test without a divider: every
// parametric bound is checked by comparing numerators against |det|.
module intersection
  import ray_pkg::*;
#(
  parameter logic signed [31:0] min_t = 32'sd0
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_valid,
  input  triangle_t i_triangle,
  input  ray_t      i_ray,
  output logic      o_valid,
  output vec3_t     o_normal,
  output logic      o_invalid,
  output logic      o_result
);

  localparam int STAGES = 4;
  localparam int SW     = DW + 1;
  localparam int MW     = SW + 34;

  logic [STAGES:1] vld_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) vld_q <= '0;
    else       vld_q <= {vld_q[STAGES-1:1], i_valid};
  end

  // ---------------- S1: edges and origin offset ----------------
  evec_t e1_d, e2_d, s_d, d_d;
  evec_t e1_q, e2_q, s_q, d_q;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      e1_d[i] = sx(i_triangle[1][i]) - sx(i_triangle[0][i]);
      e2_d[i] = sx(i_triangle[2][i]) - sx(i_triangle[0][i]);
      s_d[i]  = sx(i_ray[0][i])      - sx(i_triangle[0][i]);
      d_d[i]  = sx(i_ray[1][i]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      e1_q <= e1_d;
      e2_q <= e2_d;
      s_q  <= s_d;
      d_q  <= d_d;
    end
  end

  // ---------------- S2: cross products ----------------
  cvec_t n_d, p_d, q_d;
  cvec_t n2_q, p2_q, q2_q;
  evec_t e1_s2_q, e2_s2_q, s_s2_q, d_s2_q;

  cross3 #(.W(EW)) u_cross_n (.a_i(e1_q), .b_i(e2_q), .c_o(n_d));
  cross3 #(.W(EW)) u_cross_p (.a_i(d_q),  .b_i(e2_q), .c_o(p_d));
  cross3 #(.W(EW)) u_cross_q (.a_i(s_q),  .b_i(e1_q), .c_o(q_d));

  always_ff @(posedge i_clk) begin
    if (vld_q[1]) begin
      n2_q    <= n_d;
      p2_q    <= p_d;
      q2_q    <= q_d;
      e1_s2_q <= e1_q;
      e2_s2_q <= e2_q;
      s_s2_q  <= s_q;
      d_s2_q  <= d_q;
    end
  end

  // ---------------- S3: triple products ----------------
  function automatic logic signed [DW-1:0] dotp(input evec_t a, input cvec_t b);
    logic signed [DW-1:0] acc;
    acc = '0;
    for (int i = 0; i < 3; i++) acc += DW'($signed(a[i])) * DW'($signed(b[i]));
    return acc;
  endfunction

  logic signed [DW-1:0] det_d, u_d, v_d, t_d;
  logic signed [DW-1:0] det_q, u_q, v_q, t_q;
  logic [0:2][NW-1:0]   nh3_q;

  always_comb begin
    det_d = dotp(e1_s2_q, p2_q);
    u_d   = dotp(s_s2_q,  p2_q);
    v_d   = dotp(d_s2_q,  q2_q);
    t_d   = dotp(e2_s2_q, q2_q);
  end

  always_ff @(posedge i_clk) begin
    if (vld_q[2]) begin
      det_q <= det_d;
      u_q   <= u_d;
      v_q   <= v_d;
      t_q   <= t_d;
      for (int i = 0; i < 3; i++) nh3_q[i] <= n2_q[i][CW-1:FRAC_BITS];
    end
  end

  // Fraction bits of the normal are truncated away (floor semantics).
  logic unused_nlo;
  assign unused_nlo = ^{n2_q[0][FRAC_BITS-1:0], n2_q[1][FRAC_BITS-1:0],
                        n2_q[2][FRAC_BITS-1:0]};

  // ---------------- S4: sign-normalised bound checks ----------------
  logic                 sg;
  logic signed [SW-1:0] adet, us, vs, uv;
  logic signed [MW-1:0] tl, tr;
  logic                 hit_d, inv_d;
  vec3_t                nrm_d;

  always_comb begin
    sg    = det_q[DW-1];
    adet  = sg ? -SW'(det_q) : SW'(det_q);
    us    = sg ? -SW'(u_q)   : SW'(u_q);
    vs    = sg ? -SW'(v_q)   : SW'(v_q);
    uv    = us + vs;
    tl    = (sg ? -MW'(t_q) : MW'(t_q)) <<< FRAC_BITS;
    tr    = MW'(min_t) * MW'(adet);
    hit_d = !us[SW-1] && !vs[SW-1] && (uv <= adet) && (tl > tr);
    inv_d = (det_q == '0);
    nrm_d = '0;
    for (int i = 0; i < 3; i++) begin
      inv_d    = inv_d | ~fits32(nh3_q[i]);
      nrm_d[i] = nh3_q[i][31:0];
    end
  end

  vec3_t normal_q;
  logic  invalid_q, result_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      normal_q  <= '0;
      invalid_q <= 1'b0;
      result_q  <= 1'b0;
    end else if (vld_q[3]) begin
      normal_q  <= nrm_d;
      invalid_q <= inv_d;
      result_q  <= hit_d & ~inv_d;
    end
  end

  assign o_valid   = vld_q[STAGES];
  assign o_normal  = normal_q;
  assign o_invalid = invalid_q;
  assign o_result  = result_q;

endmodule

// File: tb/tb_intersection.sv
// Directed bench for intersection: exact wide-integer model via Cramer
// determinants, compared every cycle, plus literal expectations per case.
module tb_intersection;
  import ray_pkg::*;

  localparam logic signed [31:0] MIN_T = 32'sd0;
  localparam logic [31:0] Q1  = 32'h0001_0000, QQ = 32'h0000_4000, QH = 32'h0000_8000;
  localparam logic [31:0] QM1 = 32'hFFFF_0000, Q2 = 32'h0002_0000, BIG = 32'h7FFF_0000;

  logic      clk = 1'b0, rst = 1'b1, vld = 1'b0;
  triangle_t tri_in = '0;
  ray_t      ray_in = '0;
  logic      o_valid, o_invalid, o_result;
  vec3_t     o_normal;

  intersection #(.min_t(MIN_T)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(vld), .i_triangle(tri_in), .i_ray(ray_in),
    .o_valid(o_valid), .o_normal(o_normal), .o_invalid(o_invalid), .o_result(o_result)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  bit chk_en = 1'b0;

  typedef logic signed [199:0] big_t;
  typedef struct packed {
    logic             vld;
    logic [0:2][31:0] nrm;
    logic             inv;
    logic             res;
  } exp_t;

  function automatic big_t bx(input logic [31:0] x);
    return big_t'($signed(x));
  endfunction

  // Determinant of the 3x3 matrix with rows a, b, c.
  function automatic big_t det3(input big_t a0, a1, a2, b0, b1, b2, c0, c1, c2);
    return a0*(b1*c2 - b2*c1) - a1*(b0*c2 - b2*c0) + a2*(b0*c1 - b1*c0);
  endfunction

  function automatic exp_t model(input triangle_t t, input ray_t r);
    big_t e1[3], e2[3], s[3], d[3], n[3];
    big_t dt, u, v, tn, sh, lo, hi;
    bit   hit;
    exp_t x;
    for (int i = 0; i < 3; i++) begin
      e1[i] = bx(t[1][i]) - bx(t[0][i]);
      e2[i] = bx(t[2][i]) - bx(t[0][i]);
      s[i]  = bx(r[0][i]) - bx(t[0][i]);
      d[i]  = bx(r[1][i]);
    end
    n[0] = e1[1]*e2[2] - e1[2]*e2[1];
    n[1] = e1[2]*e2[0] - e1[0]*e2[2];
    n[2] = e1[0]*e2[1] - e1[1]*e2[0];
    dt = det3(e1[0], e1[1], e1[2], d[0], d[1], d[2], e2[0], e2[1], e2[2]);
    u  = det3(s[0], s[1], s[2], d[0], d[1], d[2], e2[0], e2[1], e2[2]);
    v  = det3(d[0], d[1], d[2], s[0], s[1], s[2], e1[0], e1[1], e1[2]);
    tn = det3(e2[0], e2[1], e2[2], s[0], s[1], s[2], e1[0], e1[1], e1[2]);
    x = '0;
    x.vld = 1'b1;
    x.inv = (dt == 0);
    lo = -(big_t'(1) <<< 31);
    hi = (big_t'(1) <<< 31) - 1;
    for (int i = 0; i < 3; i++) begin
      sh = n[i] >>> 16;
      if (sh < lo || sh > hi) x.inv = 1'b1;
      x.nrm[i] = sh[31:0];
    end
    if (dt > 0)      hit = (u >= 0) && (v >= 0) && (u + v <= dt) && (tn * 65536 > bx(MIN_T) * dt);
    else if (dt < 0) hit = (u <= 0) && (v <= 0) && (u + v >= dt) && (tn * 65536 < bx(MIN_T) * dt);
    else             hit = 1'b0;
    x.res = hit && !x.inv;
    return x;
  endfunction

  // Model delay line: an item sampled at edge k is visible after edge k+3.
  exp_t pipe0, pipe1, pipe2, cur;
  always @(posedge clk) begin
    if (rst) begin
      pipe0 <= '0; pipe1 <= '0; pipe2 <= '0; cur <= '0;
    end else begin
      pipe0 <= vld ? model(tri_in, ray_in) : '0;
      pipe1 <= pipe0;
      pipe2 <= pipe1;
      if (pipe2.vld) cur <= pipe2;
      else           cur.vld <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({o_valid, o_normal, o_invalid, o_result} !== {cur.vld, cur.nrm, cur.inv, cur.res}) begin
        errors++;
        $display("FAIL model t=%0t got v=%b n=%h inv=%b res=%b expected v=%b n=%h inv=%b res=%b",
                 $time, o_valid, o_normal, o_invalid, o_result, cur.vld, cur.nrm, cur.inv, cur.res);
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic triangle_t mk_tri(input logic [31:0] ax, ay, az, bx_, by, bz, cx, cy, cz);
    triangle_t t;
    t[0][0] = ax;  t[0][1] = ay; t[0][2] = az;
    t[1][0] = bx_; t[1][1] = by; t[1][2] = bz;
    t[2][0] = cx;  t[2][1] = cy; t[2][2] = cz;
    return t;
  endfunction

  function automatic ray_t mk_ray(input logic [31:0] ex, ey, ez, dx, dy, dz);
    ray_t r;
    r[0][0] = ex; r[0][1] = ey; r[0][2] = ez;
    r[1][0] = dx; r[1][1] = dy; r[1][2] = dz;
    return r;
  endfunction

  triangle_t        tc  [8];
  ray_t             rc  [8];
  logic [0:2][31:0] en  [8];
  bit               einv[8], eres[8];
  string            nm  [8];

  task automatic run1(input int k);
    int lat;
    @(posedge clk); #1;
    tri_in = tc[k]; ray_in = rc[k]; vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
    for (lat = 1; lat <= 10; lat++) begin
      @(negedge clk);
      if (o_valid) break;
    end
    chk({nm[k], "_latency"}, 128'(lat), 128'(4));
    chk({nm[k], "_normal"},  128'(o_normal), 128'(en[k]));
    chk({nm[k], "_invalid"}, 128'(o_invalid), 128'(einv[k]));
    chk({nm[k], "_result"},  128'(o_result), 128'(eres[k]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] vseq;
    logic [3:0] rseq;
    int         pulses;

    tc[0] = mk_tri(0, 0, 0, Q1, 0, 0, 0, Q1, 0); rc[0] = mk_ray(QQ, QQ, Q1, 0, 0, QM1);
    en[0] = {32'h0, 32'h0, Q1};  einv[0] = 0; eres[0] = 1; nm[0] = "hit";
    tc[1] = tc[0]; rc[1] = mk_ray(Q2, Q2, Q1, 0, 0, QM1);
    en[1] = {32'h0, 32'h0, Q1};  einv[1] = 0; eres[1] = 0; nm[1] = "miss";
    tc[2] = tc[0]; rc[2] = mk_ray(QQ, QQ, QM1, 0, 0, QM1);
    en[2] = {32'h0, 32'h0, Q1};  einv[2] = 0; eres[2] = 0; nm[2] = "behind";
    tc[3] = tc[0]; rc[3] = mk_ray(QH, QH, Q1, 0, 0, QM1);
    en[3] = {32'h0, 32'h0, Q1};  einv[3] = 0; eres[3] = 1; nm[3] = "edge";
    tc[4] = tc[0]; rc[4] = mk_ray(QQ, QQ, Q1, Q1, 0, 0);
    en[4] = {32'h0, 32'h0, Q1};  einv[4] = 1; eres[4] = 0; nm[4] = "parallel";
    tc[5] = mk_tri(0, 0, 0, Q1, 0, 0, Q1, 0, 0); rc[5] = rc[0];
    en[5] = '0;                  einv[5] = 1; eres[5] = 0; nm[5] = "degenerate";
    tc[6] = mk_tri(0, 0, 0, BIG, 0, 0, 0, BIG, 0); rc[6] = mk_ray(Q1, Q1, Q1, 0, 0, QM1);
    en[6] = {32'h0, 32'h0, 32'h0001_0000}; einv[6] = 1; eres[6] = 0; nm[6] = "overflow";
    tc[7] = mk_tri(0, 0, 0, 0, Q1, 0, Q1, 0, 0); rc[7] = rc[0];
    en[7] = {32'h0, 32'h0, QM1}; einv[7] = 0; eres[7] = 1; nm[7] = "flipped";

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid",   128'(o_valid),   128'(0));
    chk("reset_normal",  128'(o_normal),  128'(0));
    chk("reset_invalid", 128'(o_invalid), 128'(0));
    chk("reset_result",  128'(o_result),  128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    for (int k = 0; k < 8; k++) run1(k);

    // Four back-to-back items, then idle.
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) begin
      tri_in = tc[j]; ray_in = rc[j]; vld = 1'b1;
      @(posedge clk); #1;
    end
    vld = 1'b0;
    vseq = '0; rseq = '0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      vseq = {vseq[4:0], o_valid};
      if (j < 4) rseq = {rseq[2:0], o_result};
    end
    chk("stream_valid",  128'(vseq), 128'(6'b111100));
    chk("stream_result", 128'(rseq), 128'(4'b1001));

    // Reset lands while three items are in flight.
    @(posedge clk); #1;
    tri_in = tc[0]; ray_in = rc[0]; vld = 1'b1;
    @(posedge clk); #1;
    tri_in = tc[1]; ray_in = rc[1];
    @(posedge clk); #1;
    tri_in = tc[3]; ray_in = rc[3]; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; vld = 1'b0;
    @(negedge clk);
    chk("midrst_valid",  128'(o_valid),  128'(0));
    chk("midrst_normal", 128'(o_normal), 128'(0));
    chk("midrst_result", 128'(o_result), 128'(0));
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_valid) pulses++;
    end
    chk("midrst_no_stale", 128'(pulses), 128'(0));

    run1(0);
    run1(7);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
